// File: rtl/mem_access_scheduler_pkg.sv
// mem_access_scheduler_pkg: shared types and lane geometry for the 3-lane RAM scheduler
// Contents: FSM state encoding, RAM op type, core count, per-lane address and data widths.
package mem_access_scheduler_pkg;
   localparam int NUM_CORES = 3;
   localparam int LANE_AW   = 8;
   localparam int LANE_W    = 16;
   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_RD_ISSUE   = 2'd1,
      S_RD_CAPTURE = 2'd2,
      S_WR_ISSUE   = 2'd3
   } state_e;
   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_e;
endpackage

// File: rtl/mem_access_scheduler_lane_pack.sv
// mem_access_scheduler_lane_pack: packs one batch of core requests into the 48-bit RAM lane format
// Ports:
//   mask_i         requesting cores for the chosen op
//   op_i           OP_READ or OP_WRITE
//   core_addr_i    core i address at [8i+7:8i]
//   core_wdata_i   core i write data at [16i+15:16i]
//   mask_o         batch mask; for writes, same-address requesters above the lowest index are removed
//   ram_address_o  lane i address at [16i+7:16i], upper byte 0
//   ram_data_in_o  lane i write data at [16i+15:16i]
module mem_access_scheduler_lane_pack
   import mem_access_scheduler_pkg::*;
(
   input  logic [NUM_CORES-1:0]         mask_i,
   input  op_e                          op_i,
   input  logic [NUM_CORES*LANE_AW-1:0] core_addr_i,
   input  logic [NUM_CORES*LANE_W-1:0]  core_wdata_i,
   output logic [NUM_CORES-1:0]         mask_o,
   output logic [NUM_CORES*LANE_W-1:0]  ram_address_o,
   output logic [NUM_CORES*LANE_W-1:0]  ram_data_in_o
);
   logic [LANE_AW-1:0] mir_addr;
   logic [LANE_W-1:0]  mir_data;
   // Equality is transitive, so comparing against every lower requester is enough.
   always_comb begin
      mask_o = mask_i;
      for (int i = 1; i < NUM_CORES; i++)
         for (int j = 0; j < i; j++)
            if (op_i == OP_WRITE && mask_i[i] && mask_i[j] &&
                core_addr_i[LANE_AW*i +: LANE_AW] == core_addr_i[LANE_AW*j +: LANE_AW])
               mask_o[i] = 1'b0;
   end
   // Idle write lanes repeat the lowest active lane so their duplicate write is identical.
   always_comb begin
      mir_addr = '0;
      mir_data = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--)
         if (op_i == OP_WRITE && mask_o[i]) begin
            mir_addr = core_addr_i[LANE_AW*i +: LANE_AW];
            mir_data = core_wdata_i[LANE_W*i +: LANE_W];
         end
   end
   always_comb begin
      ram_address_o = '0;
      ram_data_in_o = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         ram_address_o[LANE_W*i +: LANE_AW] = mask_o[i] ? core_addr_i[LANE_AW*i +: LANE_AW] : mir_addr;
         ram_data_in_o[LANE_W*i +: LANE_W]  = !mask_o[i] ? mir_data :
                                              op_i == OP_WRITE ? core_wdata_i[LANE_W*i +: LANE_W] : '0;
      end
   end
endmodule

// File: rtl/mem_access_scheduler.sv
// mem_access_scheduler: batches three cores' read/write requests onto a shared 3-lane RAM
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   core_req_i      per-core request, held until granted
//   core_we_i       per-core 1=write 0=read
//   core_addr_i     core i address at [8i+7:8i]
//   core_wdata_i    core i write data at [16i+15:16i]
//   core_gnt_o      1-cycle grant pulse per core
//   core_rvalid_o   1-cycle read-data-valid pulse per core
//   core_rdata_o    core i read data at [16i+15:16i], held until that core's next rvalid
//   ram_read_o      RAM read strobe
//   ram_write_o     RAM write strobe
//   ram_address_o   lane-packed RAM address
//   ram_data_in_o   lane-packed RAM write data
//   ram_data_out_i  lane-packed registered RAM read data
module mem_access_scheduler
   import mem_access_scheduler_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CORES-1:0]         core_req_i,
   input  logic [NUM_CORES-1:0]         core_we_i,
   input  logic [NUM_CORES*LANE_AW-1:0] core_addr_i,
   input  logic [NUM_CORES*LANE_W-1:0]  core_wdata_i,
   output logic [NUM_CORES-1:0]         core_gnt_o,
   output logic [NUM_CORES-1:0]         core_rvalid_o,
   output logic [NUM_CORES*LANE_W-1:0]  core_rdata_o,
   output logic                         ram_read_o,
   output logic                         ram_write_o,
   output logic [NUM_CORES*LANE_W-1:0]  ram_address_o,
   output logic [NUM_CORES*LANE_W-1:0]  ram_data_in_o,
   input  logic [NUM_CORES*LANE_W-1:0]  ram_data_out_i
);
   state_e                      state_q, state_d;
   op_e                         last_op_q, last_op_d, sel_op;
   logic [NUM_CORES-1:0]        mask_q, mask_d, gnt_q, gnt_d, rvalid_q, rvalid_d;
   logic [NUM_CORES-1:0]        rmask, wmask, sel_mask, res_mask;
   logic [NUM_CORES*LANE_W-1:0] rdata_q, rdata_d, addr_q, addr_d, wdata_q, wdata_d;
   logic [NUM_CORES*LANE_W-1:0] pack_addr, pack_data;
   logic                        rd_q, rd_d, wr_q, wr_d, rd_sel, wr_sel;
   assign rmask    = core_req_i & ~core_we_i;
   assign wmask    = core_req_i & core_we_i;
   // Under contention the op opposite to the last issued one wins, alternating reads and writes.
   assign rd_sel   = state_q == S_IDLE && |rmask && (~|wmask || last_op_q == OP_WRITE);
   assign wr_sel   = state_q == S_IDLE && |wmask && !rd_sel;
   assign sel_op   = rd_sel ? OP_READ : OP_WRITE;
   assign sel_mask = rd_sel ? rmask : wmask;
   mem_access_scheduler_lane_pack u_pack (
      .mask_i        (sel_mask),
      .op_i          (sel_op),
      .core_addr_i   (core_addr_i),
      .core_wdata_i  (core_wdata_i),
      .mask_o        (res_mask),
      .ram_address_o (pack_addr),
      .ram_data_in_o (pack_data)
   );
   always_comb begin
      state_d   = state_q;
      last_op_d = last_op_q;
      mask_d    = mask_q;
      gnt_d     = '0;
      rvalid_d  = '0;
      rdata_d   = rdata_q;
      rd_d      = 1'b0;
      wr_d      = 1'b0;
      addr_d    = '0;
      wdata_d   = '0;
      case (state_q)
         S_IDLE: begin
            if (rd_sel) begin
               state_d   = S_RD_ISSUE;
               last_op_d = OP_READ;
               mask_d    = res_mask;
               gnt_d     = res_mask;
               rd_d      = 1'b1;
               addr_d    = pack_addr;
            end else if (wr_sel) begin
               state_d   = S_WR_ISSUE;
               last_op_d = OP_WRITE;
               gnt_d     = res_mask;
               wr_d      = 1'b1;
               addr_d    = pack_addr;
               wdata_d   = pack_data;
            end
         end
         S_RD_ISSUE: state_d = S_RD_CAPTURE;
         S_RD_CAPTURE: begin
            state_d  = S_IDLE;
            rvalid_d = mask_q;
            for (int i = 0; i < NUM_CORES; i++)
               rdata_d[LANE_W*i +: LANE_W] = mask_q[i] ? ram_data_out_i[LANE_W*i +: LANE_W]
                                                       : rdata_q[LANE_W*i +: LANE_W];
         end
         S_WR_ISSUE: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         last_op_q <= OP_WRITE;
         mask_q    <= '0;
         gnt_q     <= '0;
         rvalid_q  <= '0;
         rdata_q   <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         last_op_q <= last_op_d;
         mask_q    <= mask_d;
         gnt_q     <= gnt_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
      end
   end
   assign core_gnt_o    = gnt_q;
   assign core_rvalid_o = rvalid_q;
   assign core_rdata_o  = rdata_q;
   assign ram_read_o    = rd_q;
   assign ram_write_o   = wr_q;
   assign ram_address_o = addr_q;
   assign ram_data_in_o = wdata_q;
endmodule

// File: tb/tb_mem_access_scheduler.sv
// tb_mem_access_scheduler: directed self-checking bench with a behavioural 3-lane shared RAM
module tb_mem_access_scheduler;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_load = 1'b1;
   logic [2:0]  core_req = '0, core_we = '0;
   logic [23:0] core_addr = '0;
   logic [47:0] core_wdata = '0;
   logic [2:0]  core_gnt, core_rvalid;
   logic [47:0] core_rdata, ram_address, ram_data_in;
   logic [47:0] ram_data_out = '0;
   logic        ram_read, ram_write;
   logic [15:0] mem [256];
   int          checks = 0, errors = 0, overlap = 0;

   always #5 clk = ~clk;

   mem_access_scheduler dut (
      .clk            (clk),
      .rst            (rst),
      .core_req_i     (core_req),
      .core_we_i      (core_we),
      .core_addr_i    (core_addr),
      .core_wdata_i   (core_wdata),
      .core_gnt_o     (core_gnt),
      .core_rvalid_o  (core_rvalid),
      .core_rdata_o   (core_rdata),
      .ram_read_o     (ram_read),
      .ram_write_o    (ram_write),
      .ram_address_o  (ram_address),
      .ram_data_in_o  (ram_data_in),
      .ram_data_out_i (ram_data_out)
   );

   function automatic logic [15:0] init_val(input int k);
      logic [7:0] kb;
      kb = k[7:0];
      return k == 'h42 ? 16'd45 : k == 'h3E ? 16'd3 : k == 'h3F ? 16'd3 :
             k == 'h40 ? 16'd2 : {8'hC0, kb};
   endfunction

   always @(posedge clk) begin
      if (mem_load) begin
         for (int k = 0; k < 256; k++) mem[k] <= init_val(k);
      end else if (ram_write) begin
         for (int l = 0; l < 3; l++) mem[ram_address[16*l +: 8]] <= ram_data_in[16*l +: 16];
      end
      if (ram_read)
         ram_data_out <= {mem[ram_address[39:32]], mem[ram_address[23:16]], mem[ram_address[7:0]]};
   end

   always @(negedge clk) if (ram_read && ram_write) overlap++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      checks++; if (core_gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected 000", core_gnt); end
      checks++; if (core_rvalid !== 3'b000) begin errors++; $display("FAIL reset_rvalid: got %b expected 000", core_rvalid); end
      checks++; if ({ram_read, ram_write} !== 2'b00) begin errors++; $display("FAIL reset_ram_strobes: got %b expected 00", {ram_read, ram_write}); end
      checks++; if ({core_rdata, ram_address, ram_data_in} !== '0) begin errors++; $display("FAIL reset_buses: got %h expected 0", {core_rdata, ram_address, ram_data_in}); end
      rst = 1'b0;
      mem_load = 1'b0;
   endtask

   task automatic test_single_read();
      core_req = 3'b010; core_we = 3'b000; core_addr = {8'h00, 8'h42, 8'h00};
      tick();
      checks++; if (core_gnt !== 3'b010) begin errors++; $display("FAIL single_gnt: got %b expected 010", core_gnt); end
      checks++; if ({ram_read, ram_write} !== 2'b10) begin errors++; $display("FAIL single_strobe: got %b expected 10", {ram_read, ram_write}); end
      checks++; if (ram_address !== 48'h0000_0042_0000) begin errors++; $display("FAIL single_addr: got %h expected 000000420000", ram_address); end
      core_req = 3'b000;
      tick();
      checks++; if ({ram_read, core_gnt, core_rvalid} !== 7'b0) begin errors++; $display("FAIL single_n2_quiet: got %b expected 0", {ram_read, core_gnt, core_rvalid}); end
      tick();
      checks++; if (core_rvalid !== 3'b010) begin errors++; $display("FAIL single_rvalid: got %b expected 010", core_rvalid); end
      checks++; if (core_rdata[31:16] !== 16'd45) begin errors++; $display("FAIL single_rdata: got %0d expected 45", core_rdata[31:16]); end
      tick();
      checks++; if (core_rvalid !== 3'b000 || core_rdata[31:16] !== 16'd45) begin errors++; $display("FAIL single_hold: got rvalid %b data %0d expected 000 45", core_rvalid, core_rdata[31:16]); end
   endtask

   task automatic test_triple_read();
      core_req = 3'b111; core_we = 3'b000; core_addr = {8'h40, 8'h3F, 8'h3E};
      tick();
      checks++; if (core_gnt !== 3'b111 || ram_read !== 1'b1) begin errors++; $display("FAIL triple_gnt: got gnt %b rd %b expected 111 1", core_gnt, ram_read); end
      checks++; if (ram_address !== 48'h0040_003F_003E) begin errors++; $display("FAIL triple_addr: got %h expected 0040003f003e", ram_address); end
      core_req = 3'b000;
      tick();
      tick();
      checks++; if (core_rvalid !== 3'b111) begin errors++; $display("FAIL triple_rvalid: got %b expected 111", core_rvalid); end
      checks++; if (core_rdata !== {16'd2, 16'd3, 16'd3}) begin errors++; $display("FAIL triple_rdata: got %h expected 000200030003", core_rdata); end
      tick();
   endtask

   task automatic test_partial_write();
      core_req = 3'b001; core_we = 3'b001; core_addr = {8'h00, 8'h00, 8'h52}; core_wdata = {32'h0, 16'h1234};
      tick();
      checks++; if (core_gnt !== 3'b001 || {ram_read, ram_write} !== 2'b01) begin errors++; $display("FAIL pwrite_gnt: got gnt %b strobes %b expected 001 01", core_gnt, {ram_read, ram_write}); end
      checks++; if (ram_address !== 48'h0052_0052_0052) begin errors++; $display("FAIL pwrite_addr: got %h expected 005200520052", ram_address); end
      checks++; if (ram_data_in !== 48'h1234_1234_1234) begin errors++; $display("FAIL pwrite_data: got %h expected 123412341234", ram_data_in); end
      core_req = 3'b000;
      tick();
      checks++; if (ram_write !== 1'b0 || core_gnt !== 3'b000) begin errors++; $display("FAIL pwrite_pulse: got wr %b gnt %b expected 0 000", ram_write, core_gnt); end
      checks++; if (mem[8'h52] !== 16'h1234 || mem[8'h51] !== init_val('h51) || mem[8'h53] !== init_val('h53)) begin errors++; $display("FAIL pwrite_mem: got %h %h %h expected %h 1234 %h", mem[8'h51], mem[8'h52], mem[8'h53], init_val('h51), init_val('h53)); end
      core_req = 3'b100; core_we = 3'b000; core_addr = {8'h52, 16'h0};
      tick();
      core_req = 3'b000;
      tick();
      tick();
      checks++; if (core_rvalid !== 3'b100 || core_rdata[47:32] !== 16'h1234) begin errors++; $display("FAIL pwrite_readback: got rvalid %b data %h expected 100 1234", core_rvalid, core_rdata[47:32]); end
      tick();
   endtask

   task automatic test_write_conflict();
      core_req = 3'b101; core_we = 3'b101; core_addr = {8'h53, 8'h00, 8'h53}; core_wdata = {16'h5555, 16'h0, 16'hAAAA};
      tick();
      checks++; if (core_gnt !== 3'b001 || ram_write !== 1'b1) begin errors++; $display("FAIL conflict_first_gnt: got gnt %b wr %b expected 001 1", core_gnt, ram_write); end
      checks++; if (ram_address !== 48'h0053_0053_0053 || ram_data_in !== 48'hAAAA_AAAA_AAAA) begin errors++; $display("FAIL conflict_first_bus: got %h %h expected 005300530053 aaaaaaaaaaaa", ram_address, ram_data_in); end
      core_req = 3'b100;
      tick();
      checks++; if (core_gnt !== 3'b000 || mem[8'h53] !== 16'hAAAA) begin errors++; $display("FAIL conflict_gap: got gnt %b mem %h expected 000 aaaa", core_gnt, mem[8'h53]); end
      tick();
      checks++; if (core_gnt !== 3'b100 || ram_data_in !== 48'h5555_5555_5555) begin errors++; $display("FAIL conflict_second: got gnt %b data %h expected 100 555555555555", core_gnt, ram_data_in); end
      core_req = 3'b000;
      tick();
      checks++; if (mem[8'h53] !== 16'h5555) begin errors++; $display("FAIL conflict_mem: got %h expected 5555", mem[8'h53]); end
   endtask

   task automatic test_mixed();
      core_req = 3'b011; core_we = 3'b010; core_addr = {8'h00, 8'h54, 8'h41}; core_wdata = {16'h0, 16'hBEEF, 16'h0};
      tick();
      checks++; if ({ram_read, ram_write} !== 2'b10 || core_gnt !== 3'b001) begin errors++; $display("FAIL mixed_read_first: got strobes %b gnt %b expected 10 001", {ram_read, ram_write}, core_gnt); end
      core_req = 3'b010;
      tick();
      checks++; if ({ram_read, ram_write} !== 2'b00 || core_gnt !== 3'b000) begin errors++; $display("FAIL mixed_capture: got strobes %b gnt %b expected 00 000", {ram_read, ram_write}, core_gnt); end
      tick();
      checks++; if (core_rvalid !== 3'b001 || core_rdata[15:0] !== init_val('h41)) begin errors++; $display("FAIL mixed_rvalid: got %b %h expected 001 %h", core_rvalid, core_rdata[15:0], init_val('h41)); end
      tick();
      checks++; if ({ram_read, ram_write} !== 2'b01 || core_gnt !== 3'b010 || ram_address !== 48'h0054_0054_0054) begin errors++; $display("FAIL mixed_write: got strobes %b gnt %b addr %h expected 01 010 005400540054", {ram_read, ram_write}, core_gnt, ram_address); end
      core_req = 3'b000;
      tick();
      checks++; if (mem[8'h54] !== 16'hBEEF) begin errors++; $display("FAIL mixed_mem: got %h expected beef", mem[8'h54]); end
   endtask

   task automatic test_reset_mid_read();
      core_req = 3'b100; core_we = 3'b000; core_addr = {8'h40, 16'h0};
      tick();
      checks++; if (core_gnt !== 3'b100) begin errors++; $display("FAIL rstmid_gnt: got %b expected 100", core_gnt); end
      core_req = 3'b000;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if ({core_gnt, core_rvalid, ram_read, ram_write} !== 8'b0 || {core_rdata, ram_address, ram_data_in} !== '0) begin errors++; $display("FAIL rstmid_outputs: got %b %h expected all 0", {core_gnt, core_rvalid, ram_read, ram_write}, {core_rdata, ram_address, ram_data_in}); end
      tick();
      checks++; if (core_rvalid !== 3'b000) begin errors++; $display("FAIL rstmid_no_rvalid: got %b expected 000", core_rvalid); end
      core_req = 3'b001; core_addr = {16'h0, 8'h3F};
      tick();
      core_req = 3'b000;
      tick();
      tick();
      checks++; if (core_rvalid !== 3'b001 || core_rdata[15:0] !== 16'd3) begin errors++; $display("FAIL rstmid_recover: got %b %0d expected 001 3", core_rvalid, core_rdata[15:0]); end
      tick();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_triple_read();
      test_partial_write();
      test_write_conflict();
      test_mixed();
      test_reset_mid_read();
      checks++; if (overlap !== 0) begin errors++; $display("FAIL rd_wr_overlap: got %0d cycles expected 0", overlap); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
